ks_control_unit_mc: RTL and testbench

- Parametrised multi-cycle control unit for the K&S datapath; drives the same datapath controls as the current control unit.
- Adds configurable RAM wait states on fetch/load/store.
- Adds single-step debug mode, resumable halt and a retired-instruction counter.
- Sits between the datapath (decoded_instruction, flags) and the RAM write strobe.

---
 rtl/ks_control_unit_mc.sv | 214 +++++++++++++++++++++
 tb/tb_ks_control_unit_mc.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_control_unit_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ks_control_unit_mc : multi-cycle K&S control unit with RAM wait states,  |
// | single-step pause, resumable halt and retired-instruction counter. r1.0  |
// +--------------------------------------------------------------------------+

package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_BOV    = 4'd13,
    I_BNOV   = 4'd14,
    I_HALT   = 4'd15
  } decoded_instruction_type;
endpackage

module ks_control_unit_mc
  import k_and_s_pkg::*;
#(
  parameter int MEM_WAIT  = 0,
  parameter int CNT_WIDTH = 16,
  parameter int WAIT_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  input  logic                    step_mode,
  input  logic                    resume,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    write_reg_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic [1:0]              operation,
  output logic                    halt,
  output logic                    paused,
  output logic [CNT_WIDTH-1:0]    instr_count
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_REG      = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEM      = 4'd3;
  localparam logic [3:0] S_LOAD_WB  = 4'd4;
  localparam logic [3:0] S_STORE_WR = 4'd5;
  localparam logic [3:0] S_EXEC     = 4'd6;
  localparam logic [3:0] S_WB       = 4'd7;
  localparam logic [3:0] S_BR       = 4'd8;
  localparam logic [3:0] S_HALT     = 4'd9;
  localparam logic [3:0] S_PAUSE    = 4'd10;

  localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(MEM_WAIT);

  logic [3:0]              state_q, state_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  decoded_instruction_type instr_q, instr_d;
  logic [CNT_WIDTH-1:0]    count_q, count_d;
  logic                    retire;
  logic [1:0]              alu_op;
  logic                    alu_flags;
  logic                    br_taken;
  logic                    unused_sovf;

  assign unused_sovf = signed_overflow;
  assign instr_count = count_q;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    instr_d = instr_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (wait_q == C_WAIT_LAST) begin
          wait_d  = '0;
          state_d = S_REG;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_REG: state_d = S_DECODE;
      S_DECODE: begin
        instr_d = decoded_instruction;
        case (decoded_instruction)
          I_LOAD, I_STORE:                 state_d = S_MEM;
          I_MOVE, I_ADD, I_SUB, I_AND, I_OR: state_d = S_EXEC;
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
          I_BNNEG, I_BOV, I_BNOV:          state_d = S_BR;
          I_HALT:                          state_d = S_HALT;
          default:                         retire = 1'b1;
        endcase
      end
      S_MEM: begin
        if (wait_q == C_WAIT_LAST) begin
          wait_d  = '0;
          state_d = (instr_q == I_STORE) ? S_STORE_WR : S_LOAD_WB;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_EXEC: state_d = S_WB;
      S_LOAD_WB, S_STORE_WR, S_WB, S_BR: retire = 1'b1;
      S_HALT, S_PAUSE: begin
        if (resume) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // step_mode only matters at the retire boundary
    if (retire) state_d = step_mode ? S_PAUSE : S_FETCH;
    count_d = retire ? count_q + 1'b1 : count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      instr_q <= I_NOP;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    alu_op    = 2'b00;
    alu_flags = 1'b0;
    br_taken  = 1'b0;
    case (instr_q)
      I_ADD:    begin alu_op = 2'b00; alu_flags = 1'b1; end
      I_SUB:    begin alu_op = 2'b01; alu_flags = 1'b1; end
      I_AND:    begin alu_op = 2'b10; alu_flags = 1'b1; end
      I_OR:     begin alu_op = 2'b11; alu_flags = 1'b1; end
      I_MOVE:   alu_op = 2'b10;
      I_BRANCH: br_taken = 1'b1;
      I_BZERO:  br_taken = zero_op;
      I_BNZERO: br_taken = ~zero_op;
      I_BNEG:   br_taken = neg_op;
      I_BNNEG:  br_taken = ~neg_op;
      I_BOV:    br_taken = unsigned_overflow;
      I_BNOV:   br_taken = ~unsigned_overflow;
      default:  ;
    endcase
  end

  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    write_reg_enable = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    operation        = 2'b00;
    halt             = 1'b0;
    paused           = 1'b0;
    case (state_q)
      S_REG: begin
        ir_enable = 1'b1;
        pc_enable = 1'b1;
      end
      S_MEM: addr_sel = 1'b1;
      S_LOAD_WB: begin
        addr_sel         = 1'b1;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
      end
      S_STORE_WR: begin
        addr_sel         = 1'b1;
        ram_write_enable = 1'b1;
      end
      S_EXEC: begin
        operation        = alu_op;
        flags_reg_enable = alu_flags;
      end
      S_WB: begin
        operation        = alu_op;
        flags_reg_enable = alu_flags;
        write_reg_enable = 1'b1;
      end
      S_BR: begin
        pc_enable = 1'b1;
        branch    = br_taken;
      end
      S_HALT:  halt   = 1'b1;
      S_PAUSE: paused = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_ks_control_unit_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ks_control_unit_mc : queued cycle-by-cycle scoreboard for two control |
// | unit instances (MEM_WAIT=0/CNT_WIDTH=4 and MEM_WAIT=3). r1.0             |
// +--------------------------------------------------------------------------+

module tb_ks_control_unit_mc;
  import k_and_s_pkg::*;

  typedef struct packed {
    logic [7:0]  ctl;   // br pc ir wr as cs fl rw
    logic [1:0]  op;
    logic        h;
    logic        p;
    logic [15:0] cnt;
  } ov_t;

  localparam logic [7:0] C_BR = 8'h80, C_PC = 8'h40, C_IR = 8'h20, C_WR = 8'h10;
  localparam logic [7:0] C_AS = 8'h08, C_CS = 8'h04, C_FL = 8'h02, C_RW = 8'h01;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, rst3_n, zf, nf, uf, sf, step0, resume0, step3, resume3;
  decoded_instruction_type di0, di3;
  wire [7:0]  ctl0, ctl3;
  wire [1:0]  op0, op3;
  wire        h0, p0, h3, p3;
  wire [3:0]  cnt0;
  wire [15:0] cnt3;

  ks_control_unit_mc #(.MEM_WAIT(0), .CNT_WIDTH(4), .WAIT_W(4)) dut0 (
    .clk(clk), .rst_n(rst0_n), .decoded_instruction(di0),
    .zero_op(zf), .neg_op(nf), .unsigned_overflow(uf), .signed_overflow(sf),
    .step_mode(step0), .resume(resume0),
    .branch(ctl0[7]), .pc_enable(ctl0[6]), .ir_enable(ctl0[5]),
    .write_reg_enable(ctl0[4]), .addr_sel(ctl0[3]), .c_sel(ctl0[2]),
    .flags_reg_enable(ctl0[1]), .ram_write_enable(ctl0[0]),
    .operation(op0), .halt(h0), .paused(p0), .instr_count(cnt0)
  );

  ks_control_unit_mc #(.MEM_WAIT(3), .CNT_WIDTH(16), .WAIT_W(4)) dut3 (
    .clk(clk), .rst_n(rst3_n), .decoded_instruction(di3),
    .zero_op(1'b0), .neg_op(1'b0), .unsigned_overflow(1'b0), .signed_overflow(1'b0),
    .step_mode(step3), .resume(resume3),
    .branch(ctl3[7]), .pc_enable(ctl3[6]), .ir_enable(ctl3[5]),
    .write_reg_enable(ctl3[4]), .addr_sel(ctl3[3]), .c_sel(ctl3[2]),
    .flags_reg_enable(ctl3[1]), .ram_write_enable(ctl3[0]),
    .operation(op3), .halt(h3), .paused(p3), .instr_count(cnt3)
  );

  ov_t q0[$];
  ov_t q3[$];
  int  n_total = 0;
  int  n_pass  = 0;
  int  cyc_no  = 0;
  logic [15:0] ecnt [2];

  // Monitor: compare whatever the DUT presents against the oldest queued expectation
  always @(negedge clk) begin
    ov_t e, a;
    cyc_no <= cyc_no + 1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      a = '{ctl: ctl0, op: op0, h: h0, p: p0, cnt: {12'b0, cnt0}};
      n_total++;
      if (a === e) n_pass++;
      else $display("FAIL dut0_cycle %0d: got %h required %h", cyc_no, a, e);
    end
    if (q3.size() > 0) begin
      e = q3.pop_front();
      a = '{ctl: ctl3, op: op3, h: h3, p: p3, cnt: cnt3};
      n_total++;
      if (a === e) n_pass++;
      else $display("FAIL dut3_cycle %0d: got %h required %h", cyc_no, a, e);
    end
  end

  function automatic ov_t mk(input logic [7:0] c, input logic [1:0] o,
                             input logic h, input logic p, input logic [15:0] n);
    mk = '{ctl: c, op: o, h: h, p: p, cnt: n};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int sel, input ov_t v);
    if (sel == 0) q0.push_back(v);
    else q3.push_back(v);
    tick();
  endtask

  task automatic retire(input int sel);
    ecnt[sel] = (sel == 0) ? ((ecnt[sel] + 16'd1) & 16'h000F) : ecnt[sel] + 16'd1;
  endtask

  // Fetch / IR load / decode, then the decoder output is scrambled to prove latching
  task automatic prefix(input int sel, input int mw, input decoded_instruction_type ins);
    if (sel == 0) di0 = ins; else di3 = ins;
    for (int k = 0; k <= mw; k++) cyc(sel, mk(8'h00, 2'b00, 1'b0, 1'b0, ecnt[sel]));
    cyc(sel, mk(C_PC | C_IR, 2'b00, 1'b0, 1'b0, ecnt[sel]));
    cyc(sel, mk(8'h00, 2'b00, 1'b0, 1'b0, ecnt[sel]));
    if (sel == 0) di0 = decoded_instruction_type'(ins ^ 4'h5);
    else di3 = decoded_instruction_type'(ins ^ 4'h5);
  endtask

  task automatic run_instr(input int sel, input int mw, input decoded_instruction_type ins);
    logic [1:0] op;
    logic       b;
    prefix(sel, mw, ins);
    b  = 1'b0;
    op = 2'b00;
    case (ins)
      I_LOAD, I_STORE: begin
        for (int k = 0; k <= mw; k++) cyc(sel, mk(C_AS, 2'b00, 1'b0, 1'b0, ecnt[sel]));
        if (ins == I_LOAD) cyc(sel, mk(C_AS | C_CS | C_WR, 2'b00, 1'b0, 1'b0, ecnt[sel]));
        else cyc(sel, mk(C_AS | C_RW, 2'b00, 1'b0, 1'b0, ecnt[sel]));
        retire(sel);
      end
      I_MOVE: begin
        cyc(sel, mk(8'h00, 2'b10, 1'b0, 1'b0, ecnt[sel]));
        cyc(sel, mk(C_WR, 2'b10, 1'b0, 1'b0, ecnt[sel]));
        retire(sel);
      end
      I_ADD, I_SUB, I_AND, I_OR: begin
        op = (ins == I_ADD) ? 2'b00 : (ins == I_SUB) ? 2'b01 : (ins == I_AND) ? 2'b10 : 2'b11;
        cyc(sel, mk(C_FL, op, 1'b0, 1'b0, ecnt[sel]));
        cyc(sel, mk(C_FL | C_WR, op, 1'b0, 1'b0, ecnt[sel]));
        retire(sel);
      end
      I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
        case (ins)
          I_BRANCH: b = 1'b1;
          I_BZERO:  b = zf;
          I_BNZERO: b = ~zf;
          I_BNEG:   b = nf;
          I_BNNEG:  b = ~nf;
          I_BOV:    b = uf;
          default:  b = ~uf;
        endcase
        cyc(sel, mk(C_PC | (b ? C_BR : 8'h00), 2'b00, 1'b0, 1'b0, ecnt[sel]));
        retire(sel);
      end
      I_HALT: ;
      default: retire(sel);
    endcase
  endtask

  task automatic halt_cyc(input int n);
    for (int k = 0; k < n; k++) cyc(0, mk(8'h00, 2'b00, 1'b1, 1'b0, ecnt[0]));
  endtask

  task automatic pause_cyc(input int n);
    for (int k = 0; k < n; k++) cyc(0, mk(8'h00, 2'b00, 1'b0, 1'b1, ecnt[0]));
  endtask

  task automatic reset0(input int n);
    rst0_n  = 1'b0;
    ecnt[0] = 16'd0;
    for (int k = 0; k < n; k++) cyc(0, mk(8'h00, 2'b00, 1'b0, 1'b0, 16'd0));
    rst0_n = 1'b1;
  endtask

  initial begin
    rst0_n = 1'b0; rst3_n = 1'b0;
    zf = 1'b0; nf = 1'b0; uf = 1'b0; sf = 1'b0;
    step0 = 1'b0; resume0 = 1'b0; step3 = 1'b0; resume3 = 1'b0;
    di0 = I_NOP; di3 = I_NOP;
    ecnt[0] = 16'd0; ecnt[1] = 16'd0;
    tick();
    for (int k = 0; k < 2; k++) begin
      q3.push_back(mk(8'h00, 2'b00, 1'b0, 1'b0, 16'd0));
      cyc(0, mk(8'h00, 2'b00, 1'b0, 1'b0, 16'd0));
    end

    // MEM_WAIT=3 load: 4 fetch cycles, IR at 5, MEM 7..10, writeback at 11
    rst3_n = 1'b1;
    run_instr(1, 3, I_LOAD);
    cyc(1, mk(8'h00, 2'b00, 1'b0, 1'b0, ecnt[1]));
    rst3_n  = 1'b0;
    ecnt[1] = 16'd0;
    cyc(1, mk(8'h00, 2'b00, 1'b0, 1'b0, 16'd0));

    // ADD, STORE, HALT; halt holds with resume low
    rst0_n = 1'b1;
    run_instr(0, 0, I_ADD);
    run_instr(0, 0, I_STORE);
    run_instr(0, 0, I_HALT);
    halt_cyc(3);
    resume0 = 1'b1;
    halt_cyc(1);
    resume0 = 1'b0;

    // Conditional branches and MOVE
    zf = 1'b0;
    run_instr(0, 0, I_BZERO);
    run_instr(0, 0, I_BNZERO);
    run_instr(0, 0, I_MOVE);
    nf = 1'b1;
    run_instr(0, 0, I_BNEG);
    uf = 1'b1;
    run_instr(0, 0, I_BNOV);
    run_instr(0, 0, I_BOV);
    nf = 1'b0; uf = 1'b0; zf = 1'b1;
    run_instr(0, 0, I_BZERO);
    run_instr(0, 0, I_BNNEG);
    run_instr(0, 0, I_SUB);
    run_instr(0, 0, I_OR);
    run_instr(0, 0, I_AND);

    // Reset during STORE memory phase, then during HALT
    prefix(0, 0, I_STORE);
    reset0(2);
    run_instr(0, 0, I_NOP);
    run_instr(0, 0, I_HALT);
    halt_cyc(1);
    reset0(2);

    // Single-step: pause after each retire, step_mode drop while paused is ignored
    step0 = 1'b1;
    run_instr(0, 0, I_ADD);
    pause_cyc(5);
    step0 = 1'b0;
    pause_cyc(5);
    step0 = 1'b1;
    resume0 = 1'b1;
    pause_cyc(1);
    resume0 = 1'b0;
    run_instr(0, 0, I_ADD);
    pause_cyc(3);
    resume0 = 1'b1;
    pause_cyc(1);
    resume0 = 1'b0;
    run_instr(0, 0, I_ADD);
    pause_cyc(2);
    step0 = 1'b0;
    resume0 = 1'b1;
    pause_cyc(1);
    resume0 = 1'b0;

    // Counter wrap with a 4-bit counter: 3 -> ... 15 -> 0 -> 1
    for (int i = 0; i < 14; i++) run_instr(0, 0, (i % 2 == 1) ? I_BRANCH : I_NOP);

    // resume held high: one halt cycle, and ignored during normal execution
    resume0 = 1'b1;
    run_instr(0, 0, I_HALT);
    halt_cyc(1);
    run_instr(0, 0, I_ADD);
    resume0 = 1'b0;
    cyc(0, mk(8'h00, 2'b00, 1'b0, 1'b0, ecnt[0]));

    for (int k = 0; k < 4 && (q0.size() > 0 || q3.size() > 0); k++) tick();
    n_total++;
    if (q0.size() == 0 && q3.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d/%0d pending required 0/0", q0.size(), q3.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
